// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks:
// segment bit positions, hex glyph table and polarity helpers.
package seg7_pkg;

    localparam int SEG_A = 7;
    localparam int SEG_B = 6;
    localparam int SEG_C = 5;
    localparam int SEG_D = 4;
    localparam int SEG_E = 3;
    localparam int SEG_F = 2;
    localparam int SEG_G = 1;
    localparam int SEG_P = 0;

    // Glyphs as ABCDEFG with A in bit 6; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] GLYPH_TAB = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,
        7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33,
        7'h79, 7'h6D, 7'h30, 7'h7E
    };

    localparam bit POL_ACTIVE_LOW  = 1'b1;
    localparam bit POL_ACTIVE_HIGH = 1'b0;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to ABCDEFG glyph decoder.
// Bit 6 of the result is segment A, bit 0 is segment G.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPH_TAB[nib_i];

endmodule

// File: rtl/seg7_scan_nx.sv
// Multiplexed hex display scanner with prescaler, PWM dimming,
// ghosting guard, leading-zero suppression and frame snapshot.
module seg7_scan_nx
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 2,
    parameter int DIM_BITS       = 4,
    parameter bit AN_ACTIVE_LOW  = POL_ACTIVE_LOW,
    parameter bit SEG_ACTIVE_LOW = POL_ACTIVE_LOW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_suppress,
    input  logic [DIM_BITS-1:0]   bright,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            cat
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};
    localparam logic [7:0] CAT_OFF = {8{SEG_ACTIVE_LOW}};

    logic [SW-1:0]         slot_q, slot_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DIM_BITS-1:0]   pwm_q, pwm_d;
    logic [4*DIGITS-1:0]   data_q;
    logic [DIGITS-1:0]     dp_q, blank_q;
    logic                  lz_q;
    logic [DIM_BITS-1:0]   bright_q;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [7:0]            cat_q, cat_d;

    logic                  frame_start, slot_last, idx_last;
    logic                  eligible, pwm_on, lit, run;
    logic [4*DIGITS-1:0]   f_data;
    logic [DIGITS-1:0]     f_dp, f_blank, supp;
    logic                  f_lz;
    logic [DIM_BITS-1:0]   f_bright;
    logic [3:0]            cur_nib;
    logic [6:0]            glyph;
    logic [DIGITS-1:0]     an_raw;
    logic [7:0]            cat_raw;

    // The frame's first cycle uses the live inputs it is capturing.
    assign frame_start = (slot_q == '0) && (idx_q == '0);
    assign f_data   = frame_start ? data        : data_q;
    assign f_dp     = frame_start ? dp          : dp_q;
    assign f_blank  = frame_start ? blank       : blank_q;
    assign f_lz     = frame_start ? lz_suppress : lz_q;
    assign f_bright = frame_start ? bright      : bright_q;

    assign slot_last = (slot_q == SW'(REFRESH_DIV - 1));
    assign idx_last  = (idx_q == IW'(DIGITS - 1));
    assign eligible  = (slot_q >= SW'(GUARD));
    assign cur_nib   = f_data[4*int'(idx_q) +: 4];

    hex_to_seg7 u_dec (
        .nib_i (cur_nib),
        .seg_o (glyph)
    );

    always_comb begin
        slot_d = slot_last ? '0 : slot_q + SW'(1);
        idx_d  = idx_q;
        if (slot_last) begin
            idx_d = idx_last ? '0 : idx_q + IW'(1);
        end
        // Counting only eligible cycles keeps the duty exact even
        // when the PWM period divides the slot length.
        pwm_d = eligible ? pwm_q + DIM_BITS'(1) : pwm_q;
    end

    always_comb begin
        supp = '0;
        run  = f_lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run     = run && (f_data[4*k +: 4] == 4'h0);
            supp[k] = run;
        end
    end

    always_comb begin
        pwm_on  = (f_bright == '1) || (pwm_q < f_bright);
        lit     = eligible && !f_blank[idx_q] && pwm_on;
        an_raw  = '0;
        cat_raw = '0;
        if (lit) begin
            an_raw  = DIGITS'(1) << idx_q;
            cat_raw = {supp[idx_q] ? 7'h00 : glyph, f_dp[idx_q]};
        end
        an_d  = an_raw ^ AN_OFF;
        cat_d = cat_raw ^ CAT_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            idx_q    <= '0;
            pwm_q    <= '0;
            data_q   <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            lz_q     <= 1'b0;
            bright_q <= '0;
            an_q     <= AN_OFF;
            cat_q    <= CAT_OFF;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
            pwm_q  <= pwm_d;
            an_q   <= an_d;
            cat_q  <= cat_d;
            if (frame_start) begin
                data_q   <= data;
                dp_q     <= dp;
                blank_q  <= blank;
                lz_q     <= lz_suppress;
                bright_q <= bright;
            end
        end
    end

    assign an  = an_q;
    assign cat = cat_q;

endmodule

// File: tb/tb_seg7_scan_nx.sv
// Directed bench for seg7_scan_nx: 4 digits, 4-cycle slots,
// 1-cycle guard, 2-bit brightness, active-low pins.
module tb_seg7_scan_nx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        lz_suppress = 1'b0;
    logic [1:0]  bright = '0;
    logic [3:0]  an;
    logic [7:0]  cat;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [1:0]  bright;
        int          dig;
        logic [3:0]  an;
        logic [7:0]  cat;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    seg7_scan_nx #(
        .DIGITS         (4),
        .REFRESH_DIV    (4),
        .GUARD          (1),
        .DIM_BITS       (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .dp          (dp),
        .blank       (blank),
        .lz_suppress (lz_suppress),
        .bright      (bright),
        .an          (an),
        .cat         (cat)
    );

    task automatic chk(input string nm, input logic [3:0] ea,
                       input logic [7:0] ec);
        tests++;
        if (an !== ea || cat !== ec) begin
            fails++;
            $display("FAIL %s: an=%b cat=%h, expected an=%b cat=%h",
                     nm, an, cat, ea, ec);
        end
    endtask

    task automatic chk_cnt(input string nm, input int got,
                           input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: count=%0d, expected %0d", nm, got, exp);
        end
    endtask

    // cyc counts negedges since rst dropped; the outputs seen at
    // negedge k belong to scan cycle k-1.
    task automatic goto(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic reset_run(input logic [15:0] d, input logic [3:0] p,
                             input logic [3:0] b, input logic z,
                             input logic [1:0] br);
        @(negedge clk);
        data = d;
        dp = p;
        blank = b;
        lz_suppress = z;
        bright = br;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset", 4'hF, 8'hFF);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic count_on(input logic [1:0] br, input int exp,
                            input string nm);
        int on;
        on = 0;
        reset_run(16'h8888, 4'h0, 4'h0, 1'b0, br);
        for (int k = 1; k <= 32; k++) begin
            goto(k);
            if (an !== 4'hF) on++;
        end
        chk_cnt(nm, on, exp);
    endtask

    initial begin
        tbl[0]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3, 0, 4'hE, 8'h71};
        tbl[1]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3, 1, 4'hD, 8'h11};
        tbl[2]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3, 2, 4'hB, 8'h25};
        tbl[3]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3, 3, 4'h7, 8'h9F};
        tbl[4]  = '{16'h0005, 4'h4, 4'h0, 1'b1, 2'd3, 3, 4'h7, 8'hFF};
        tbl[5]  = '{16'h0005, 4'h4, 4'h0, 1'b1, 2'd3, 2, 4'hB, 8'hFE};
        tbl[6]  = '{16'h0005, 4'h4, 4'h0, 1'b1, 2'd3, 1, 4'hD, 8'hFF};
        tbl[7]  = '{16'h0005, 4'h4, 4'h0, 1'b1, 2'd3, 0, 4'hE, 8'h49};
        tbl[8]  = '{16'h0005, 4'h4, 4'h0, 1'b0, 2'd3, 3, 4'h7, 8'h03};
        tbl[9]  = '{16'h0005, 4'h4, 4'h0, 1'b0, 2'd3, 2, 4'hB, 8'h02};
        tbl[10] = '{16'h0005, 4'h4, 4'h0, 1'b0, 2'd3, 1, 4'hD, 8'h03};
        tbl[11] = '{16'h8888, 4'h0, 4'h9, 1'b0, 2'd3, 0, 4'hF, 8'hFF};
        tbl[12] = '{16'h8888, 4'h0, 4'h9, 1'b0, 2'd3, 1, 4'hD, 8'h01};
        tbl[13] = '{16'h8888, 4'h0, 4'h9, 1'b0, 2'd3, 2, 4'hB, 8'h01};
        tbl[14] = '{16'h8888, 4'h0, 4'h9, 1'b0, 2'd3, 3, 4'hF, 8'hFF};
        tbl[15] = '{16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 0, 4'hE, 8'h03};
        tbl[16] = '{16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 1, 4'hD, 8'hFF};
        tbl[17] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 2'd0, 1, 4'hF, 8'hFF};

        for (int i = 0; i < 18; i++) begin
            reset_run(tbl[i].data, tbl[i].dp, tbl[i].blank,
                      tbl[i].lz, tbl[i].bright);
            goto(4 * tbl[i].dig + 3);
            chk($sformatf("vec%0d", i), tbl[i].an, tbl[i].cat);
        end

        // Guard cycle at the start of each slot stays dark.
        reset_run(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
        goto(1);
        chk("guard_d0", 4'hF, 8'hFF);
        goto(5);
        chk("guard_d1", 4'hF, 8'hFF);
        goto(6);
        chk("first_lit_d1", 4'hD, 8'h11);

        // Data change mid-frame waits for the next frame.
        reset_run(16'h1111, 4'h0, 4'h0, 1'b0, 2'd3);
        goto(5);
        data = 16'h2222;
        goto(7);
        chk("coh_d1_old", 4'hD, 8'h9F);
        goto(11);
        chk("coh_d2_old", 4'hB, 8'h9F);
        goto(15);
        chk("coh_d3_old", 4'h7, 8'h9F);
        goto(19);
        chk("coh_d0_new", 4'hE, 8'h25);
        goto(23);
        chk("coh_d1_new", 4'hD, 8'h25);
        goto(31);
        chk("coh_d3_new", 4'h7, 8'h25);

        // Brightness duty over 32 cycles, 24 of them eligible.
        count_on(2'd1, 6, "bright1");
        count_on(2'd0, 0, "bright0");
        count_on(2'd3, 24, "bright3");

        // Reset during digit 2 aborts the frame.
        reset_run(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
        goto(8);
        chk("pre_rst_d1", 4'hD, 8'h11);
        goto(9);
        rst = 1'b1;
        data = 16'h3456;
        goto(10);
        chk("mid_rst", 4'hF, 8'hFF);
        goto(12);
        rst = 1'b0;
        cyc = 0;
        goto(1);
        chk("restart_guard", 4'hF, 8'hFF);
        goto(3);
        chk("restart_d0", 4'hE, 8'h41);
        goto(7);
        chk("restart_d1", 4'hD, 8'h49);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
